// File: rtl/alu_seq.sv
// Multi-cycle ALU with a start/done handshake: single-cycle add/sub/and/or,
// bit-serial shifts and a shift-and-add multiplier. Results and flags are registered.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             eq,
  output logic             ble,
  output logic             overflow
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_SLL = 3'd4, OP_SRL = 3'd5, OP_SRA = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     sh_q, sh_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 eq_q, eq_d, ble_q, ble_d, ovf_q, ovf_d;

  logic                 fin, fin_ovf;
  logic [WIDTH-1:0]     fin_res, fin_a, fin_b, sum, sh_first, sh_step;
  logic [2*WIDTH-1:0]   acc_step;
  logic [SHW-1:0]       k;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [2:0] o);
    case (o)
      OP_SLL:  shift1 = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  shift1 = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift1 = v;
    endcase
  endfunction

  assign k        = B[SHW-1:0];
  assign sum      = (op == OP_SUB) ? (A - B) : (A + B);
  assign sh_first = shift1(A, op);
  assign sh_step  = shift1(sh_q, op_q);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    eq_d     = eq_q;
    ble_d    = ble_q;
    ovf_d    = ovf_q;
    fin      = 1'b0;
    fin_res  = '0;
    fin_ovf  = 1'b0;
    fin_a    = a_q;
    fin_b    = b_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d  = op;
          a_d   = A;
          b_d   = B;
          fin_a = A;
          fin_b = B;
          case (op)
            OP_ADD, OP_SUB: begin
              fin     = 1'b1;
              fin_res = sum;
              fin_ovf = ((op == OP_ADD) ? (A[WIDTH-1] == B[WIDTH-1]) : (A[WIDTH-1] != B[WIDTH-1]))
                        && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: begin fin = 1'b1; fin_res = A & B; end
            OP_OR:  begin fin = 1'b1; fin_res = A | B; end
            OP_MUL: begin
              // first multiplier bit is consumed on the accepting edge
              acc_d    = B[0] ? {{WIDTH{1'b0}}, A} : '0;
              mcand_d  = {{(WIDTH-1){1'b0}}, A, 1'b0};
              mplier_d = {1'b0, B[WIDTH-1:1]};
              cnt_d    = SHW'(WIDTH - 1);
              state_d  = S_RUN;
            end
            default: begin
              if (k == '0) begin
                fin = 1'b1; fin_res = A;
              end else if (k == SHW'(1)) begin
                fin = 1'b1; fin_res = sh_first;
              end else begin
                sh_d    = sh_first;
                cnt_d   = k - SHW'(1);
                state_d = S_RUN;
              end
            end
          endcase
        end
      end
      default: begin
        if (op_q == OP_MUL) begin
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_res = acc_step[WIDTH-1:0];
            fin_ovf = |acc_step[2*WIDTH-1:WIDTH];
          end else begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - SHW'(1);
          end
        end else begin
          if (cnt_q == SHW'(1)) begin
            fin     = 1'b1;
            fin_res = sh_step;
          end else begin
            sh_d  = sh_step;
            cnt_d = cnt_q - SHW'(1);
          end
        end
      end
    endcase
    if (fin) begin
      state_d = S_DONE;
      res_d   = fin_res;
      ovf_d   = fin_ovf;
      eq_d    = (fin_a == fin_b);
      ble_d   = ($signed(fin_a) <= $signed(fin_b));
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      eq_q     <= 1'b0;
      ble_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      eq_q     <= eq_d;
      ble_q    <= ble_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign ALUResult = res_q;
  assign eq        = eq_q;
  assign ble       = ble_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=16); expected values are hand-computed.
module tb_alu_seq;
  logic        CLK = 1'b0, Reset = 1'b1, start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] A = '0, B = '0;
  logic        busy, done, eq, ble, overflow;
  logic [15:0] ALUResult;
  int          n_chk = 0, n_fail = 0, lat;
  logic        bsy_ok;

  alu_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .ALUResult(ALUResult), .eq(eq), .ble(ble), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive a request at a negedge; return at the negedge of cycle N+1
  task automatic go(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge CLK);
    start = 1'b0; op = 3'($urandom); A = 16'($urandom); B = 16'($urandom);
  endtask

  // count cycles from N+1 until done, requiring busy on every cycle before it
  task automatic wait_done(input int maxc, output int l, output logic ok);
    l = 1; ok = 1'b1;
    while (!done && l < maxc) begin
      if (!busy) ok = 1'b0;
      @(negedge CLK);
      l++;
    end
  endtask

  task automatic flags(input string tag, input logic [15:0] r, input logic e, input logic b, input logic v);
    chk({tag, "_res"}, ALUResult, r);
    chk({tag, "_eq"}, eq, e);
    chk({tag, "_ble"}, ble, b);
    chk({tag, "_ovf"}, overflow, v);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    flags("rst", 16'h0, 0, 0, 0);
    @(negedge CLK); Reset = 1'b0; @(negedge CLK);

    // add with signed overflow
    go(3'd0, 16'h7FFF, 16'h0001);
    chk("add_done", done, 1); chk("add_busy", busy, 0);
    flags("add", 16'h8000, 0, 0, 1);
    @(negedge CLK);
    chk("add_done_pulse", done, 0); chk("add_hold", ALUResult, 16'h8000);

    go(3'd1, 16'h0005, 16'h0005);
    chk("sub0_done", done, 1); flags("sub0", 16'h0000, 1, 1, 0);
    go(3'd1, 16'hFFFF, 16'h0001);
    flags("sub1", 16'hFFFE, 0, 1, 0);
    go(3'd1, 16'h8000, 16'h0001);
    flags("sub2", 16'h7FFF, 0, 1, 1);

    // sra by 4 with an ignored start while running
    @(negedge CLK);
    go(3'd6, 16'h8000, 16'h0004);
    chk("sra_n1_busy", busy, 1); chk("sra_n1_done", done, 0);
    start = 1'b1; op = 3'd0; A = 16'h0001; B = 16'h0001;
    @(negedge CLK);
    chk("sra_n2_busy", busy, 1);
    @(negedge CLK);
    start = 1'b0;
    chk("sra_n3_busy", busy, 1); chk("sra_n3_done", done, 0);
    @(negedge CLK);
    chk("sra_n4_done", done, 1); chk("sra_n4_busy", busy, 0);
    flags("sra", 16'hF800, 0, 1, 0);
    @(negedge CLK);
    chk("sra_after_done", done, 0); chk("sra_after_res", ALUResult, 16'hF800);

    go(3'd4, 16'h0001, 16'h0003);
    wait_done(20, lat, bsy_ok);
    chk("sll3_lat", lat, 3); chk("sll3_busy", bsy_ok, 1); chk("sll3_res", ALUResult, 16'h0008);
    go(3'd5, 16'h8001, 16'h0001);
    chk("srl1_done", done, 1); chk("srl1_busy", busy, 0); chk("srl1_res", ALUResult, 16'h4000);

    // multiplier
    go(3'd7, 16'd300, 16'd300);
    wait_done(40, lat, bsy_ok);
    chk("mul0_lat", lat, 16); chk("mul0_busy", bsy_ok, 1);
    flags("mul0", 16'h5F90, 1, 1, 1);
    go(3'd7, 16'd12, 16'd11);
    wait_done(40, lat, bsy_ok);
    chk("mul1_lat", lat, 16);
    flags("mul1", 16'h0084, 0, 0, 0);

    // reset mid-operation
    @(negedge CLK);
    go(3'd7, 16'd300, 16'd300);
    repeat (6) @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk("rmid_busy", busy, 0); chk("rmid_done", done, 0);
    flags("rmid", 16'h0, 0, 0, 0);
    repeat (3) begin
      @(negedge CLK);
      chk("rmid_nodone", done, 0);
    end
    Reset = 1'b0;
    @(negedge CLK);
    go(3'd0, 16'd3, 16'd4);
    chk("radd_done", done, 1); chk("radd_res", ALUResult, 16'h0007);

    // back-to-back single-cycle ops with start held high
    @(negedge CLK);
    start = 1'b1; op = 3'd2; A = 16'h0F0F; B = 16'h00FF;
    @(negedge CLK);
    chk("b2b_and_done", done, 1); chk("b2b_and_res", ALUResult, 16'h000F);
    op = 3'd3;
    @(negedge CLK);
    chk("b2b_or_done", done, 1); chk("b2b_or_res", ALUResult, 16'h0FFF);
    start = 1'b0;
    @(negedge CLK);
    chk("b2b_end_done", done, 0);

    go(3'd4, 16'h1234, 16'h0000);
    chk("sll0_done", done, 1); chk("sll0_busy", busy, 0); chk("sll0_res", ALUResult, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
